// File: rtl/mem_master_pkg.sv
// Shared constants and FSM state encoding for the mem_master bus engine.
package mem_master_pkg;

  localparam int ADDR_W     = 13;
  localparam int RAM_ADDR_W = 10;
  localparam int DATA_W     = 8;

  localparam logic [ADDR_W-1:0] RAM_BASE_DEFAULT = 13'h1C00;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACC    = 3'd1,
    RD_DONE   = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5,
    WR_DONE   = 3'd6,
    ERR_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/mem_master.sv
// mem_master: turns single core requests into ROM/RAM bus cycles on a shared
// tristate data bus. Every output comes straight from a register.
// Optional feature: define MEM_MASTER_RDBUF_EN to add a one-entry read buffer
// that answers a repeated read without touching the bus.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RAM_BASE    = RAM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] bus_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              rom_ena,
  output logic              ram_ena,
  output logic              bus_read,
  output logic              bus_write
);

  // Countdown start value: the last RD_ACC cycle is the one where it reads 0.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              drive;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  // The data bus is ours only from WR_SETUP through WR_HOLD.
  assign bus_data = drive ? wdata_q : {DATA_W{1'bz}};

`ifdef MEM_MASTER_RDBUF_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  assign hit      = buf_vld && (buf_addr == addr);
  assign hit_data = buf_data;

  // Fill on every completed bus read; drop the entry when RAM under it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
    end else if (state == RD_ACC && wait_cnt == 4'd0) begin
      buf_vld  <= 1'b1;
      buf_addr <= bus_addr;
      buf_data <= bus_data;
    end else if (state == IDLE && req && we && addr >= RAM_BASE && buf_addr == addr) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Write data is captured on acceptance and only observed while driving.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) wdata_q <= wdata;
  end

  // Transaction FSM; outputs are set on the edge that enters each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rom_ena   <= 1'b0;
      ram_ena   <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      rdata     <= '0;
      drive     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (we) begin
              if (addr >= RAM_BASE) begin
                state    <= WR_SETUP;
                ram_ena  <= 1'b1;
                drive    <= 1'b1;
                bus_addr <= addr;
              end else begin
                // ROM is read-only: report it without touching the bus.
                state <= ERR_DONE;
                ack   <= 1'b1;
                err   <= 1'b1;
              end
            end else if (hit) begin
              state <= RD_DONE;
              ack   <= 1'b1;
              rdata <= hit_data;
            end else begin
              state    <= RD_ACC;
              rom_ena  <= (addr < RAM_BASE);
              ram_ena  <= (addr >= RAM_BASE);
              bus_read <= 1'b1;
              bus_addr <= addr;
              wait_cnt <= WAIT_LAST;
            end
          end
        end
        RD_ACC: begin
          if (wait_cnt == 4'd0) begin
            state    <= RD_DONE;
            rdata    <= bus_data;
            ack      <= 1'b1;
            rom_ena  <= 1'b0;
            ram_ena  <= 1'b0;
            bus_read <= 1'b0;
            bus_addr <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WR_SETUP: begin
          state     <= WR_STROBE;
          bus_write <= 1'b1;
        end
        WR_STROBE: begin
          state     <= WR_HOLD;
          bus_write <= 1'b0;
        end
        WR_HOLD: begin
          state    <= WR_DONE;
          ram_ena  <= 1'b0;
          drive    <= 1'b0;
          bus_addr <= '0;
          ack      <= 1'b1;
        end
        RD_DONE, WR_DONE, ERR_DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Testbench for mem_master: a transaction-level model predicts every output
// cycle by cycle from the access timeline; directed transactions add literal checks.
module tb_mem_master;

  localparam int          W     = 1;
  localparam logic [12:0] RBASE = 13'h1C00;
`ifdef MEM_MASTER_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        busy, ack, err, rom_ena, ram_ena, bus_read, bus_write;
  logic [7:0]  rdata;
  logic [12:0] bus_addr;
  wire  [7:0]  bus_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_master #(.WAIT_CYCLES(W), .RAM_BASE(RBASE)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err), .bus_addr(bus_addr),
    .bus_data(bus_data), .rom_ena(rom_ena), .ram_ena(ram_ena),
    .bus_read(bus_read), .bus_write(bus_write)
  );

  // ROM contents are a fixed function of the address.
  function automatic logic [7:0] rom_val(input logic [12:0] a);
    if (a == 13'h0005) return 8'hA5;
    if (a == 13'h1BFF) return 8'h5A;
    return a[7:0] ^ 8'h3B;
  endfunction

  // Memory devices on the bus.
  logic [7:0] ram_arr [0:1023];
  int cnt_bw = 0;
  assign bus_data = (bus_read && rom_ena) ? rom_val(bus_addr) :
                    (bus_read && ram_ena) ? ram_arr[bus_addr[9:0]] : 8'bz;

  always @(posedge bus_write) begin
    cnt_bw <= cnt_bw + 1;
    if (ram_ena) ram_arr[bus_addr[9:0]] <= bus_data;
  end

  // Activity counters sampled mid-cycle.
  int cnt_rd = 0, cnt_rom = 0, cnt_ram = 0, cnt_ack = 0;
  always @(negedge clk) begin
    cnt_rd  <= cnt_rd  + int'(bus_read);
    cnt_rom <= cnt_rom + int'(rom_ena);
    cnt_ram <= cnt_ram + int'(ram_ena);
    cnt_ack <= cnt_ack + int'(ack);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, described by its kind, the
  // cycle index since acceptance (1 = first cycle after the accepting edge)
  // and the index of the ack cycle.
  logic       m_act = 1'b0;
  int         m_k = 0, m_len = 0, m_kind = 0; // kind 0 bus read, 1 buffered read, 2 RAM write, 3 ROM write
  logic [12:0] m_addr = '0;
  logic [7:0]  m_wd = '0, m_pend = '0, m_rdata = '0;
  logic [7:0]  ref_ram [0:1023];
  logic        bv = 1'b0;
  logic [12:0] ba = '0;
  logic [7:0]  bd = '0;

  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    if (a < RBASE) return rom_val(a);
    return ref_ram[a[9:0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act   <= 1'b0;
      m_rdata <= '0;
      bv      <= 1'b0;
    end else if (m_act) begin
      if (m_k == m_len) m_act <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_len && m_kind == 0) m_rdata <= m_pend;
      end
    end else if (req) begin
      m_act  <= 1'b1;
      m_k    <= 1;
      m_addr <= addr;
      m_wd   <= wdata;
      if (we && addr < RBASE) begin
        m_kind <= 3; m_len <= 1;
      end else if (we) begin
        m_kind <= 2; m_len <= 4;
        ref_ram[addr[9:0]] <= wdata;
        if (bv && ba == addr) bv <= 1'b0;
      end else if (RDBUF && bv && ba == addr) begin
        m_kind <= 1; m_len <= 1; m_rdata <= bd;
      end else begin
        m_kind <= 0; m_len <= W + 1; m_pend <= ref_rd(addr);
        if (RDBUF) begin bv <= 1'b1; ba <= addr; bd <= ref_rd(addr); end
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic rd, wr, e_ack;
      rd    = m_act && m_kind == 0 && m_k <= W;
      wr    = m_act && m_kind == 2 && m_k <= 3;
      e_ack = m_act && m_k == m_len;
      chk("busy",      32'(busy),      32'(m_act));
      chk("ack",       32'(ack),       32'(e_ack));
      chk("err",       32'(err),       32'(e_ack && m_kind == 3));
      chk("rom_ena",   32'(rom_ena),   32'(rd && m_addr < RBASE));
      chk("ram_ena",   32'(ram_ena),   32'((rd && m_addr >= RBASE) || wr));
      chk("bus_read",  32'(bus_read),  32'(rd));
      chk("bus_write", 32'(bus_write), 32'(wr && m_k == 2));
      chk("bus_addr",  32'(bus_addr),  32'((rd || wr) ? m_addr : 13'h0));
      chk("rdata",     32'(rdata),     32'(m_rdata));
      if (wr) chk("bus_data_drv", 32'(bus_data), 32'(m_wd));
    end
  end

  // One transaction from an idle DUT; returns ack latency and err at ack.
  task automatic xact(input logic w, input logic [12:0] a, input logic [7:0] d,
                      output int lat, output logic e);
    int i;
    @(posedge clk); #2;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #2;
    req = 1'b0;
    lat = 0; e = 1'b0; i = 1;
    while (lat == 0 && i <= 40) begin
      @(negedge clk);
      if (ack) begin lat = i; e = err; end
      i++;
    end
    if (lat == 0) chk("ack_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  int   lat, s_rd, s_rom, s_ram, s_bw, s_ack, ph, idle_n;
  logic e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 chk_on = 1'b1;
    @(negedge clk);
    chk("reset_busy",  32'(busy),  32'(0));
    chk("reset_rdata", 32'(rdata), 32'(0));
    @(posedge clk); #2 rst = 1'b0;

    // ROM read of 0x0005
    s_rd = cnt_rd; s_rom = cnt_rom;
    xact(1'b0, 13'h0005, 8'h00, lat, e);
    chk("rom_read_lat",   32'(lat),   32'(2));
    chk("rom_read_data",  32'(rdata), 32'(8'hA5));
    chk("rom_read_err",   32'(e),     32'(0));
    chk("rom_read_cycles",32'(cnt_rd - s_rd), 32'(1));
    chk("rom_ena_cycles", 32'(cnt_rom - s_rom), 32'(1));

    // RAM write then read back
    s_bw = cnt_bw;
    xact(1'b1, 13'h1C10, 8'h3C, lat, e);
    chk("ram_wr_lat",    32'(lat),   32'(4));
    chk("ram_wr_strobe", 32'(cnt_bw - s_bw), 32'(1));
    chk("ram_wr_cell",   32'(ram_arr[10'h010]), 32'(8'h3C));
    xact(1'b0, 13'h1C10, 8'h00, lat, e);
    chk("ram_rd_data",   32'(rdata), 32'(8'h3C));

    // ROM write: error, no bus activity, rdata kept
    s_rom = cnt_rom; s_ram = cnt_ram; s_bw = cnt_bw;
    xact(1'b1, 13'h0100, 8'hFF, lat, e);
    chk("rom_wr_lat",  32'(lat), 32'(1));
    chk("rom_wr_err",  32'(e),   32'(1));
    chk("rom_wr_ena",  32'((cnt_rom - s_rom) + (cnt_ram - s_ram)), 32'(0));
    chk("rom_wr_bw",   32'(cnt_bw - s_bw), 32'(0));
    chk("rdata_hold",  32'(rdata), 32'(8'h3C));

    // Decode boundary
    xact(1'b1, 13'h1C00, 8'h77, lat, e);
    s_rom = cnt_rom; s_ram = cnt_ram;
    xact(1'b0, 13'h1BFF, 8'h00, lat, e);
    chk("bnd_rom_data", 32'(rdata), 32'(8'h5A));
    chk("bnd_rom_sel",  32'(cnt_rom - s_rom), 32'(1));
    chk("bnd_rom_nram", 32'(cnt_ram - s_ram), 32'(0));
    s_rom = cnt_rom; s_ram = cnt_ram;
    xact(1'b0, 13'h1C00, 8'h00, lat, e);
    chk("bnd_ram_data", 32'(rdata), 32'(8'h77));
    chk("bnd_ram_sel",  32'(cnt_ram - s_ram), 32'(1));
    chk("bnd_ram_nrom", 32'(cnt_rom - s_rom), 32'(0));

    // Repeated read of 0x0005
    xact(1'b0, 13'h0005, 8'h00, lat, e);
    s_rd = cnt_rd;
    xact(1'b0, 13'h0005, 8'h00, lat, e);
    chk("rpt_data", 32'(rdata), 32'(8'hA5));
`ifdef MEM_MASTER_RDBUF_EN
    chk("buf_hit_lat",   32'(lat), 32'(1));
    chk("buf_hit_nobus", 32'(cnt_rd - s_rd), 32'(0));
    xact(1'b0, 13'h1C10, 8'h00, lat, e);
    xact(1'b1, 13'h1C10, 8'h96, lat, e);
    s_rd = cnt_rd;
    xact(1'b0, 13'h1C10, 8'h00, lat, e);
    chk("buf_inval_lat",  32'(lat), 32'(2));
    chk("buf_inval_bus",  32'(cnt_rd - s_rd), 32'(1));
    chk("buf_inval_data", 32'(rdata), 32'(8'h96));
`else
    chk("nobuf_lat", 32'(lat), 32'(2));
    chk("nobuf_bus", 32'(cnt_rd - s_rd), 32'(1));
`endif

    // Reset during WR_STROBE
    @(posedge clk); #2;
    req = 1'b1; we = 1'b1; addr = 13'h1C20; wdata = 8'h44;
    @(posedge clk); #2 req = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("rstw_strobe_on", 32'(bus_write), 32'(1));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rstw_busy", 32'(busy),      32'(0));
    chk("rstw_bw",   32'(bus_write), 32'(0));
    chk("rstw_ram",  32'(ram_ena),   32'(0));
    chk("rstw_ack",  32'(ack),       32'(0));
    chk("rstw_addr", 32'(bus_addr),  32'(0));
    @(posedge clk); #1 s_ack = cnt_ack;
    repeat (4) @(posedge clk);
    #1 chk("rstw_no_ack", 32'(cnt_ack - s_ack), 32'(0));

    // Back-to-back with req held high
    @(posedge clk); #2;
    req = 1'b1; we = 1'b0; addr = 13'h1C00;
    s_ack = cnt_ack;
    @(posedge clk); #2;
    we = 1'b1; addr = 13'h1C01; wdata = 8'hC3;
    ph = 0; idle_n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ph == 0 && !busy) ph = 1;
      if (ph == 1) begin
        if (!busy) idle_n++;
        else begin ph = 2; req = 1'b0; end
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(idle_n), 32'(1));
    chk("b2b_acks", 32'(cnt_ack - s_ack), 32'(2));
    chk("b2b_wr",   32'(ram_arr[10'h001]), 32'(8'hC3));
    chk("b2b_rd",   32'(rdata), 32'(8'h77));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the number of read access cycles (range 1..15) before read data is sampled.
REQ-002 The block SHALL have parameter RAM_BASE, default 13'h1C00, meaning the first RAM address; addresses below it select ROM.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1, meaning a core access request, sampled only while busy=0.
REQ-006 The block SHALL have port we, input, 1, meaning 1=write, 0=read, sampled with req.
REQ-007 The block SHALL have port addr, input, 13, meaning the core byte address.
REQ-008 The block SHALL have port wdata, input, 8, meaning the core write data.
REQ-009 The block SHALL have port busy, output, 1, meaning a transaction is in progress.
REQ-010 The block SHALL have port ack, output, 1, meaning a one-cycle completion pulse.
REQ-011 The block SHALL have port rdata, output, 8, meaning read data, valid while ack=1 on a read.
REQ-012 The block SHALL have port err, output, 1, meaning a one-cycle pulse with ack for an illegal access.
REQ-013 The block SHALL have port bus_addr, output, 13, meaning the memory address; RAM uses bits [9:0].
REQ-014 The block SHALL have port bus_data, inout, 8, meaning the shared memory data bus.
REQ-015 The block SHALL have port rom_ena, output, 1, meaning the ROM enable.
REQ-016 The block SHALL have port ram_ena, output, 1, meaning the RAM enable.
REQ-017 The block SHALL have port bus_read, output, 1, meaning the memory output enable.
REQ-018 The block SHALL have port bus_write, output, 1, meaning the RAM write strobe; RAM captures data on its rising edge.

Function
REQ-019 All outputs SHALL be registered; bus_data SHALL be driven only in write states, and SHALL be high-Z otherwise.
REQ-020 The FSM SHALL have the states IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_STROBE, WR_HOLD, WR_DONE and ERR_DONE.
REQ-021 In IDLE, if req=1, the block SHALL latch addr/we/wdata, set busy=1 and leave IDLE at the same edge.
REQ-022 Decode SHALL be: addr>=RAM_BASE selects RAM (ram_ena), otherwise ROM (rom_ena); exactly one enable SHALL be high during a bus cycle.
REQ-023 For a read, the block SHALL assert the enable, bus_read=1 and bus_addr for WAIT_CYCLES cycles (RD_ACC).
REQ-024 For a read, the block SHALL sample bus_data into rdata at the last RD_ACC edge, then enter RD_DONE: ack=1, bus signals low, so ack rises WAIT_CYCLES+1 cycles after acceptance.
REQ-025 For a write to RAM, the sequence SHALL be: WR_SETUP (ram_ena=1, data driven, bus_write=0), WR_STROBE (bus_write=1), WR_HOLD (bus_write=0, data and address held), WR_DONE (ack, bus released); ack SHALL be 4 cycles after acceptance.
REQ-026 A write to ROM space SHALL generate no bus activity: the FSM SHALL go to ERR_DONE, pulsing ack=1 and err=1 one cycle after acceptance.
REQ-027 From any *_DONE state, the FSM SHALL return to IDLE and busy SHALL drop in that same cycle; a req held high SHALL be accepted at the next edge (back-to-back, one idle cycle between bus cycles).
REQ-028 rdata SHALL hold its value until the next read completes.

Reset
REQ-029 When rst=1 at an edge, the FSM SHALL enter IDLE and busy, ack, err, rom_ena, ram_ena, bus_read and bus_write SHALL all be 0, with bus_addr=0, rdata=0 and bus_data high-Z, overriding any state.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no ack; a reset during WR_STROBE SHALL leave bus_write falling to 0.

Configuration
REQ-031 With MEM_MASTER_RDBUF_EN defined, a one-entry read buffer (valid, address, data) SHALL be present: a read hitting a valid entry SHALL ack one cycle after acceptance with no bus activity, a miss SHALL fill the entry, a RAM write to the entry's address SHALL invalidate it, and reset SHALL clear valid.
REQ-032 Without MEM_MASTER_RDBUF_EN, every read SHALL perform a full bus cycle and no buffer registers SHALL exist.

Structure
REQ-033 A package mem_master_pkg SHALL hold the FSM state enum, the default RAM_BASE, and the address/data width constants (13, 10, 8).
REQ-034 There SHALL be no sub-module; the tristate driver and FSM SHALL live in mem_master.

Verification
REQ-035 Read: ROM preload mem[0x0005]=0xA5, WAIT_CYCLES=1 → bus_read/rom_ena high 1 cycle, ack 2 cycles after acceptance, rdata=0xA5, err=0.
REQ-036 Write then read: write 0x3C to 0x1C10 → one bus_write rising edge, ack at +4, RAM[0x010]=0x3C; a subsequent read of 0x1C10 returns 0x3C.
REQ-037 ROM write: write to 0x0100 → ack=err=1 at +1, no enable/strobe ever asserted.
REQ-038 Reset mid-write: rst during WR_STROBE → all outputs 0 next cycle, bus_data=Z, no ack.
REQ-039 Back-to-back: req held high for read 0x1C00 then write 0x1C01 → one idle cycle between bus cycles, two acks, never both enables high.
REQ-040 With MEM_MASTER_RDBUF_EN: reading 0x0005 twice gives the second ack at +1 with no bus_read; after a write to a buffered RAM address, the next read goes to the bus.
